// File: rtl/uart_if.sv
// Application-side bundle for uart_core: byte transmit handshake plus receive strobe and flags.
`timescale 1ns/1ps
interface uart_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_parity_err;
    logic       rx_frame_err;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err
    );
endinterface

// File: rtl/uart_core.sv
// Full-duplex UART with parametrised baud, data width, parity and stop bits.
// tx: IDLE idle line | START start bit | DATA data bits LSB first | PARITY parity bit | STOP stop bit(s)
// rx: IDLE armed | START mid-start check | DATA sampling | PARITY sampling | STOP check | WAIT_HIGH line held low
`timescale 1ns/1ps
module uart_core #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic  clk,
    input  logic  rst,
    uart_if.slave bus,
    output logic  txd,
    input  logic  rxd
);
    localparam int DIV       = (CLK_HZ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
    localparam int BIT_CLKS  = DIV * OVERSAMPLE;
    localparam int HALF_CLKS = BIT_CLKS / 2;
    localparam int STOP_CLKS = STOP_BITS * BIT_CLKS;
    localparam int CW        = $clog2(STOP_CLKS);

    localparam logic [CW-1:0] BIT_LOAD  = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(HALF_CLKS - 1);
    localparam logic [CW-1:0] STOP_LOAD = CW'(STOP_CLKS - 1);
    localparam logic [2:0]    BITS_LOAD = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

    tx_state_t              tx_state, tx_state_nxt;
    logic [CW-1:0]          tx_cnt, tx_cnt_nxt;
    logic [2:0]             tx_bits, tx_bits_nxt;
    logic [DATA_BITS-1:0]   tx_sh, tx_sh_nxt;
    logic                   tx_par, tx_par_nxt;
    logic                   txd_nxt;
    logic                   tx_ready_c;

    rx_state_t              rx_state, rx_state_nxt;
    logic [CW-1:0]          rx_cnt, rx_cnt_nxt;
    logic [2:0]             rx_bits, rx_bits_nxt;
    logic [DATA_BITS-1:0]   rx_sh, rx_sh_nxt;
    logic                   rx_par, rx_par_nxt;
    logic [7:0]             rx_data_q, rx_data_nxt;
    logic                   rx_valid_q, rx_valid_nxt;
    logic                   rx_perr_q, rx_perr_nxt;
    logic                   rx_ferr_q, rx_ferr_nxt;
    logic                   rx_perr_calc;
    logic                   rxd_meta, rxs, rxs_d;

    // ---------------- transmitter ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bits  <= '0;
            tx_sh    <= '0;
            tx_par   <= 1'b0;
            txd      <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_bits  <= tx_bits_nxt;
            tx_sh    <= tx_sh_nxt;
            tx_par   <= tx_par_nxt;
            txd      <= txd_nxt;
        end
    end

    // Ready during the last stop clock lets a queued byte follow with no idle gap.
    assign tx_ready_c  = (tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_cnt == '0);
    assign bus.tx_ready = tx_ready_c;

    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt - CW'(1);
        tx_bits_nxt  = tx_bits;
        tx_sh_nxt    = tx_sh;
        tx_par_nxt   = tx_par;
        txd_nxt      = txd;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_nxt = tx_cnt;
                txd_nxt    = 1'b1;
            end
            TX_START: if (tx_cnt == '0) begin
                tx_state_nxt = TX_DATA;
                tx_cnt_nxt   = BIT_LOAD;
                tx_bits_nxt  = BITS_LOAD;
                txd_nxt      = tx_sh[0];
            end
            TX_DATA: if (tx_cnt == '0) begin
                tx_cnt_nxt = BIT_LOAD;
                if (tx_bits == '0) begin
                    if (PARITY != 0) begin
                        tx_state_nxt = TX_PARITY;
                        txd_nxt      = tx_par;
                    end else begin
                        tx_state_nxt = TX_STOP;
                        tx_cnt_nxt   = STOP_LOAD;
                        txd_nxt      = 1'b1;
                    end
                end else begin
                    tx_bits_nxt = tx_bits - 3'd1;
                    tx_sh_nxt   = tx_sh >> 1;
                    txd_nxt     = tx_sh[1];
                end
            end
            TX_PARITY: if (tx_cnt == '0) begin
                tx_state_nxt = TX_STOP;
                tx_cnt_nxt   = STOP_LOAD;
                txd_nxt      = 1'b1;
            end
            TX_STOP: if (tx_cnt == '0) begin
                tx_state_nxt = TX_IDLE;
                txd_nxt      = 1'b1;
            end
            default: begin
                tx_state_nxt = TX_IDLE;
                txd_nxt      = 1'b1;
            end
        endcase
        if (tx_ready_c && bus.tx_valid) begin
            tx_state_nxt = TX_START;
            tx_cnt_nxt   = BIT_LOAD;
            tx_sh_nxt    = bus.tx_data[DATA_BITS-1:0];
            tx_par_nxt   = (PARITY == 1) ? ~(^bus.tx_data[DATA_BITS-1:0])
                                         :  (^bus.tx_data[DATA_BITS-1:0]);
            txd_nxt      = 1'b0;
        end
    end

    // ---------------- receiver ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_meta <= 1'b1;
            rxs      <= 1'b1;
            rxs_d    <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxs      <= rxd_meta;
            rxs_d    <= rxs;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bits    <= '0;
            rx_sh      <= '0;
            rx_par     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_state   <= rx_state_nxt;
            rx_cnt     <= rx_cnt_nxt;
            rx_bits    <= rx_bits_nxt;
            rx_sh      <= rx_sh_nxt;
            rx_par     <= rx_par_nxt;
            rx_data_q  <= rx_data_nxt;
            rx_valid_q <= rx_valid_nxt;
            rx_perr_q  <= rx_perr_nxt;
            rx_ferr_q  <= rx_ferr_nxt;
        end
    end

    assign rx_perr_calc = (PARITY == 1) ? ~(^rx_sh ^ rx_par) :
                          (PARITY == 2) ?  (^rx_sh ^ rx_par) : 1'b0;

    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt - CW'(1);
        rx_bits_nxt  = rx_bits;
        rx_sh_nxt    = rx_sh;
        rx_par_nxt   = rx_par;
        rx_data_nxt  = rx_data_q;
        rx_valid_nxt = 1'b0;
        rx_perr_nxt  = rx_perr_q;
        rx_ferr_nxt  = rx_ferr_q;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_nxt = rx_cnt;
                if (rxs_d && !rxs) begin
                    rx_state_nxt = RX_START;
                    rx_cnt_nxt   = HALF_LOAD;
                end
            end
            RX_START: if (rx_cnt == '0) begin
                if (rxs) begin
                    rx_state_nxt = RX_IDLE;
                end else begin
                    rx_state_nxt = RX_DATA;
                    rx_cnt_nxt   = BIT_LOAD;
                    rx_bits_nxt  = BITS_LOAD;
                end
            end
            RX_DATA: if (rx_cnt == '0) begin
                rx_cnt_nxt = BIT_LOAD;
                rx_sh_nxt  = {rxs, rx_sh[DATA_BITS-1:1]};
                if (rx_bits == '0)
                    rx_state_nxt = (PARITY != 0) ? RX_PARITY : RX_STOP;
                else
                    rx_bits_nxt = rx_bits - 3'd1;
            end
            RX_PARITY: if (rx_cnt == '0) begin
                rx_state_nxt = RX_STOP;
                rx_cnt_nxt   = BIT_LOAD;
                rx_par_nxt   = rxs;
            end
            RX_STOP: if (rx_cnt == '0) begin
                rx_state_nxt = rxs ? RX_IDLE : RX_WAIT_HIGH;
                rx_data_nxt  = 8'(rx_sh);
                rx_valid_nxt = 1'b1;
                rx_perr_nxt  = rx_perr_calc;
                rx_ferr_nxt  = ~rxs;
            end
            RX_WAIT_HIGH: begin
                rx_cnt_nxt = rx_cnt;
                if (rxs) rx_state_nxt = RX_IDLE;
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    assign bus.rx_data       = rx_data_q;
    assign bus.rx_valid      = rx_valid_q;
    assign bus.rx_parity_err = rx_perr_q;
    assign bus.rx_frame_err  = rx_ferr_q;
endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: 8N1 (loopback or driven rxd), 8E1 loopback and 7O1 driven rxd.
`timescale 1ns/1ps
module tb_uart_core;
    localparam int CLK_HZ   = 2000000;
    localparam int BAUD     = 31250;
    localparam int OVS      = 16;
    localparam int BIT_CLKS = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic txd_a, txd_b, txd_c;
    logic rxd_a, rxd_a_drv = 1'b1, rxd_c = 1'b1, loop_a = 1'b1;

    int n_chk = 0, n_fail = 0;
    int cnt_a = 0, cnt_b = 0, cnt_c = 0;
    logic [7:0] cap_b [2];
    logic [1:0] err_b [2];

    uart_if bus_a ();
    uart_if bus_b ();
    uart_if bus_c ();

    assign rxd_a = loop_a ? txd_a : rxd_a_drv;

    uart_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OVS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
        u_8n1 (.clk(clk), .rst(rst), .bus(bus_a), .txd(txd_a), .rxd(rxd_a));
    uart_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OVS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
        u_8e1 (.clk(clk), .rst(rst), .bus(bus_b), .txd(txd_b), .rxd(txd_b));
    uart_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OVS), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1))
        u_7o1 (.clk(clk), .rst(rst), .bus(bus_c), .txd(txd_c), .rxd(rxd_c));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus_a.rx_valid) cnt_a++;
        if (bus_b.rx_valid) begin
            if (cnt_b < 2) begin
                cap_b[cnt_b] = bus_b.rx_data;
                err_b[cnt_b] = {bus_b.rx_parity_err, bus_b.rx_frame_err};
            end
            cnt_b++;
        end
        if (bus_c.rx_valid) cnt_c++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int get_cnt(input int which);
        return (which == 0) ? cnt_a : (which == 1) ? cnt_b : cnt_c;
    endfunction

    task automatic wait_cnt(input int which, input int target, input int budget, input string tag);
        int n = 0;
        while (get_cnt(which) < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, get_cnt(which), target);
    endtask

    // Sends one byte on the 8N1 instance and checks every bit boundary of the line.
    task automatic send_tx_a(input logic [7:0] d, input string tag);
        logic [9:0] fr;
        int bad_ready = 0;
        fr = {1'b1, d, 1'b0};
        @(negedge clk);
        check({tag, "_ready_pre"}, bus_a.tx_ready, 1);
        bus_a.tx_data  = d;
        bus_a.tx_valid = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 640; k++) begin
            @(negedge clk);
            if (k == 0) begin
                bus_a.tx_valid = 1'b0;
                bus_a.tx_data  = ~d;
            end
            if (k % 64 == 0 || k % 64 == 63)
                check($sformatf("%s_txd_bit%0d_clk%0d", tag, k / 64, k % 64), txd_a, fr[k / 64]);
            if (k < 639 && bus_a.tx_ready) bad_ready++;
            if (k == 639) check({tag, "_ready_back"}, bus_a.tx_ready, 1);
        end
        check({tag, "_ready_low_cycles"}, bad_ready, 0);
    endtask

    task automatic drive_rx(input int which, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (which == 0) rxd_a_drv = bits[i];
            else            rxd_c     = bits[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] fr1, fr2;
        logic        exp_bit;
        bus_a.tx_data = 8'h00; bus_a.tx_valid = 1'b0;
        bus_b.tx_data = 8'h00; bus_b.tx_valid = 1'b0;
        bus_c.tx_data = 8'h00; bus_c.tx_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_txd",      txd_a, 1);
        check("rst_ready",    bus_a.tx_ready, 1);
        check("rst_rx_valid", bus_a.rx_valid, 0);
        check("rst_rx_data",  bus_a.rx_data, 0);
        check("rst_perr",     bus_a.rx_parity_err, 0);
        check("rst_ferr",     bus_a.rx_frame_err, 0);
        check("rst_txd_8e1",  txd_b, 1);

        // 1: 8N1 loopback of 0x55
        send_tx_a(8'h55, "t1");
        wait_cnt(0, 1, 2000, "t1_rx_count");
        check("t1_rx_data", bus_a.rx_data, 8'h55);
        check("t1_perr",    bus_a.rx_parity_err, 0);
        check("t1_ferr",    bus_a.rx_frame_err, 0);

        // 2: 8E1 back-to-back 0x77 (parity 0) then 0x01 (parity 1)
        fr1 = {1'b1, 1'b0, 8'h77, 1'b0};
        fr2 = {1'b1, 1'b1, 8'h01, 1'b0};
        @(negedge clk);
        check("t2_ready_pre", bus_b.tx_ready, 1);
        bus_b.tx_data  = 8'h77;
        bus_b.tx_valid = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 1408; k++) begin
            @(negedge clk);
            if (k == 0)   bus_b.tx_data  = 8'h01;
            if (k == 704) bus_b.tx_valid = 1'b0;
            exp_bit = (k < 704) ? fr1[k / 64] : fr2[(k - 704) / 64];
            if (k % 64 == 0 || k % 64 == 63)
                check($sformatf("t2_txd_clk%0d", k), txd_b, exp_bit);
            if (k == 703) check("t2_ready_back", bus_b.tx_ready, 1);
        end
        wait_cnt(1, 2, 3000, "t2_rx_count");
        check("t2_rx0_data", cap_b[0], 8'h77);
        check("t2_rx0_errs", err_b[0], 2'b00);
        check("t2_rx1_data", cap_b[1], 8'h01);
        check("t2_rx1_errs", err_b[1], 2'b00);

        // 3: injected 0x41 with stop bit low, then a break
        loop_a = 1'b0;
        repeat (10) @(negedge clk);
        drive_rx(0, {6'b0, 1'b0, 8'h41, 1'b0}, 10);
        repeat (2000) @(negedge clk);
        check("t3_count",   cnt_a, 2);
        check("t3_rx_data", bus_a.rx_data, 8'h41);
        check("t3_ferr",    bus_a.rx_frame_err, 1);
        check("t3_perr",    bus_a.rx_parity_err, 0);
        rxd_a_drv = 1'b1;
        repeat (200) @(negedge clk);
        check("t3_count_release", cnt_a, 2);
        drive_rx(0, {6'b0, 1'b1, 8'h5A, 1'b0}, 10);
        repeat (100) @(negedge clk);
        check("t3_rearm_count", cnt_a, 3);
        check("t3_rearm_data",  bus_a.rx_data, 8'h5A);
        check("t3_rearm_ferr",  bus_a.rx_frame_err, 0);

        // 4: 7O1, good parity then flipped parity
        drive_rx(1, {6'b0, 1'b1, 1'b1, 7'h41, 1'b0}, 10);
        repeat (100) @(negedge clk);
        check("t4_good_count", cnt_c, 1);
        check("t4_good_data",  bus_c.rx_data, 8'h41);
        check("t4_good_perr",  bus_c.rx_parity_err, 0);
        drive_rx(1, {6'b0, 1'b1, 1'b0, 7'h41, 1'b0}, 10);
        repeat (100) @(negedge clk);
        check("t4_bad_count", cnt_c, 2);
        check("t4_bad_data",  bus_c.rx_data, 8'h41);
        check("t4_bad_perr",  bus_c.rx_parity_err, 1);
        check("t4_bad_ferr",  bus_c.rx_frame_err, 0);
        check("t4_bit7",      bus_c.rx_data[7], 0);

        // 5: 20-clock glitch is a false start
        rxd_a_drv = 1'b0;
        repeat (20) @(negedge clk);
        rxd_a_drv = 1'b1;
        repeat (200) @(negedge clk);
        check("t5_count", cnt_a, 3);
        check("t5_data",  bus_a.rx_data, 8'h5A);
        check("t5_ferr",  bus_a.rx_frame_err, 0);
        check("t5_perr",  bus_a.rx_parity_err, 0);

        // 6: reset during bit 4 of a transmission, then a fresh frame
        loop_a = 1'b1;
        @(negedge clk);
        bus_a.tx_data  = 8'h30;
        bus_a.tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_a.tx_valid = 1'b0;
        repeat (4 * BIT_CLKS + 20) @(negedge clk);
        check("t6_txd_bit4_before_rst", txd_a, 0);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_txd",   txd_a, 1);
        check("t6_rst_ready", bus_a.tx_ready, 1);
        @(negedge clk);
        check("t6_rst_rx_valid", bus_a.rx_valid, 0);
        check("t6_rst_rx_data",  bus_a.rx_data, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (800) @(negedge clk);
        check("t6_no_strobe", cnt_a, 3);
        send_tx_a(8'h30, "t6");
        wait_cnt(0, 4, 2000, "t6_rx_count");
        check("t6_rx_data", bus_a.rx_data, 8'h30);
        check("t6_ferr",    bus_a.rx_frame_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
